// File: rtl/vector_mem_access_unit.sv
// Strided vector load/store sequencer for VECTOR_MEMORY.
// Takes one vector instruction (base, byte stride, load/store) and splits the
// VEC_BYTES-byte vector into 4-byte beats. Each beat drives RE/WE, BA, VO and WD.
// For loads, the RD beats are gathered in a shadow vector. The shadow is
// published on LD_DATA in the DONE cycle, so a partly built vector is never seen.
module vector_mem_access_unit #(
   parameter int unsigned VEC_BYTES = 16,
   parameter int unsigned READ_LAT  = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic                   is_store_i,
   input  logic [31:0]            base_i,
   input  logic [7:0]             stride_i,
   input  logic [8*VEC_BYTES-1:0] st_data_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [8*VEC_BYTES-1:0] ld_data_o,
   output logic                   mem_re_o,
   output logic                   mem_we_o,
   output logic [31:0]            mem_ba_o,
   output logic [31:0]            mem_vo_o,
   output logic [31:0]            mem_wd_o,
   input  logic [31:0]            mem_rd_i
);

   localparam int unsigned BEATS = VEC_BYTES / 4;
   localparam int unsigned VW    = 8 * VEC_BYTES;
   localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Four packed lane offsets. Each lane wraps mod 256, so stride 0 makes a broadcast.
   function automatic logic [31:0] lane_offsets(input logic [7:0] stride);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < 4; i++) begin
         v[8*i +: 8] = 8'(i) * stride;
      end
      return v;
   endfunction

   state_e          state_q;
   logic [BW-1:0]   beat_q;
   logic            busy_q;
   logic            done_q;
   logic [VW-1:0]   ld_data_q;
   logic            mem_re_q;
   logic            mem_we_q;
   logic [31:0]     mem_ba_q;
   logic [31:0]     mem_vo_q;
   logic [31:0]     mem_wd_q;

   // Read tracking pipe: one valid/beat-index tag per outstanding read.
   logic            pipe_vld_q [READ_LAT];
   logic [BW-1:0]   pipe_idx_q [READ_LAT];

   // Operands and load shadow. These have no reset (see the data-path block).
   logic            is_store_q;
   logic [7:0]      stride_q;
   logic [VW-1:0]   st_data_q;
   logic [VW-1:0]   shadow_q;

   logic            accept;
   logic            rd_fire;
   logic [BW-1:0]   rd_idx;
   logic [BW-1:0]   next_beat;
   logic [VW-1:0]   ld_merged;

   // START is taken only while not busy. DONE counts as not busy, so back-to-back ops are allowed.
   assign accept    = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign rd_fire   = pipe_vld_q[READ_LAT-1];
   assign rd_idx    = pipe_idx_q[READ_LAT-1];
   assign next_beat = beat_q + BW'(1);

   // Shadow with the beat arriving this cycle merged in. This is the value published at completion.
   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      ld_merged = shadow_q;
      ld_merged[32*int'(rd_idx) +: 32] = mem_rd_i;
   end

   // Sequencer FSM with registered bus, status and load-result outputs.
   // NOTE: sequential state uses non-blocking (<=) assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         beat_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ld_data_q <= '0;
         mem_re_q  <= 1'b0;
         mem_we_q  <= 1'b0;
         mem_ba_q  <= '0;
         mem_vo_q  <= '0;
         mem_wd_q  <= '0;
         for (int j = 0; j < int'(READ_LAT); j++) begin
            pipe_vld_q[j] <= 1'b0;
            pipe_idx_q[j] <= '0;
         end
      end else begin
         // Tag each issued read. The tag reaches the last stage when its RD is valid.
         pipe_vld_q[0] <= mem_re_q;
         pipe_idx_q[0] <= beat_q;
         for (int j = 1; j < int'(READ_LAT); j++) begin
            pipe_vld_q[j] <= pipe_vld_q[j-1];
            pipe_idx_q[j] <= pipe_idx_q[j-1];
         end

         done_q <= 1'b0;

         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  // Beat 0 is driven straight from the inputs sampled at acceptance.
                  state_q  <= S_ISSUE;
                  busy_q   <= 1'b1;
                  beat_q   <= '0;
                  mem_re_q <= !is_store_i;
                  mem_we_q <= is_store_i;
                  mem_ba_q <= base_i;
                  mem_vo_q <= lane_offsets(stride_i);
                  mem_wd_q <= is_store_i ? st_data_i[31:0] : 32'h0;
               end else begin
                  state_q <= S_IDLE;
               end
            end

            S_ISSUE: begin
               if (beat_q == LAST_BEAT) begin
                  mem_re_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  mem_ba_q <= '0;
                  mem_vo_q <= '0;
                  mem_wd_q <= '0;
                  if (is_store_q) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_DRAIN;
                  end
               end else begin
                  beat_q   <= next_beat;
                  mem_ba_q <= mem_ba_q + {22'b0, stride_q, 2'b00};
                  if (is_store_q) begin
                     mem_wd_q <= st_data_q[32*int'(next_beat) +: 32];
                  end
               end
            end

            S_DRAIN: begin
               if (rd_fire && (rd_idx == LAST_BEAT)) begin
                  state_q   <= S_DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  ld_data_q <= ld_merged;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Operand registers and load shadow capture.
   // NOTE: this data path has no reset. Operands are written at acceptance before they are used.
   // The shadow only reaches LD_DATA after every beat has overwritten it.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         is_store_q <= is_store_i;
         stride_q   <= stride_i;
         st_data_q  <= st_data_i;
      end
      if (rd_fire) begin
         shadow_q[32*int'(rd_idx) +: 32] <= mem_rd_i;
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign ld_data_o = ld_data_q;
   assign mem_re_o  = mem_re_q;
   assign mem_we_o  = mem_we_q;
   assign mem_ba_o  = mem_ba_q;
   assign mem_vo_o  = mem_vo_q;
   assign mem_wd_o  = mem_wd_q;

endmodule

// File: tb/tb_vector_mem_access_unit.sv
// Testbench for vector_mem_access_unit.
// A scoreboard queues the expected bus beats and completions when each op is launched.
// A negedge monitor pops and compares them as the DUT produces them.
module tb_vector_mem_access_unit;

   localparam int VB    = 16;
   localparam int RL    = 1;
   localparam int BEATS = VB / 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            is_store = 1'b0;
   logic [31:0]     base = '0;
   logic [7:0]      stride = '0;
   logic [8*VB-1:0] st_data = '0;
   logic            busy, done, mem_re, mem_we;
   logic [8*VB-1:0] ld_data;
   logic [31:0]     mem_ba, mem_vo, mem_wd;
   logic [31:0]     mem_rd = '0;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int          cyc;
      logic [31:0] ba;
      logic [31:0] vo;
      logic [31:0] wd;
      logic        re;
      logic        we;
   } beat_t;

   typedef struct {
      int              cyc;
      logic [8*VB-1:0] ld;
   } done_t;

   beat_t           beat_sb[$];
   done_t           done_sb[$];
   logic [8*VB-1:0] model_ld = '0;

   localparam logic [127:0] LD_T2 = 128'h0F0E0D0C0B0A09080706050403020100;

   vector_mem_access_unit #(.VEC_BYTES(VB), .READ_LAT(RL)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .is_store_i (is_store),
      .base_i     (base),
      .stride_i   (stride),
      .st_data_i  (st_data),
      .busy_o     (busy),
      .done_o     (done),
      .ld_data_o  (ld_data),
      .mem_re_o   (mem_re),
      .mem_we_o   (mem_we),
      .mem_ba_o   (mem_ba),
      .mem_vo_o   (mem_vo),
      .mem_wd_o   (mem_wd),
      .mem_rd_i   (mem_rd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory contents: the byte at address a is a[7:0].
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      return a[7:0];
   endfunction

   // Memory model, READ_LAT=1: RD is valid in the cycle after RE. Outside that cycle RD carries junk.
   logic        pend = 1'b0;
   logic [31:0] pend_rd = '0;
   always @(negedge clk) begin
      pend = mem_re;
      for (int i = 0; i < 4; i++)
         pend_rd[8*i +: 8] = mem_byte(mem_ba + {24'b0, mem_vo[8*i +: 8]});
   end
   always @(posedge clk) begin
      #1;
      mem_rd = pend ? pend_rd : 32'hDEADBEEF;
   end

   // Queue the expectations for an op accepted at the end of cycle c0.
   task automatic push_op(input logic st, input logic [31:0] b, input logic [7:0] s,
                          input logic [127:0] d, input int c0, input int nb, input bit want_done);
      logic [31:0]  ba, vo;
      logic [127:0] ld;
      beat_t        e;
      done_t        dn;
      vo = '0;
      for (int i = 0; i < 4; i++) vo[8*i +: 8] = 8'((i * int'(s)) % 256);
      ld = model_ld;
      for (int k = 0; k < nb; k++) begin
         ba    = b + 32'(k * 4 * int'(s));
         e.cyc = c0 + 1 + k;
         e.ba  = ba;
         e.vo  = vo;
         e.re  = !st;
         e.we  = st;
         e.wd  = st ? d[32*k +: 32] : 32'h0;
         beat_sb.push_back(e);
         if (!st)
            for (int i = 0; i < 4; i++)
               ld[8*(4*k+i) +: 8] = mem_byte(ba + {24'b0, vo[8*i +: 8]});
      end
      if (want_done) begin
         dn.cyc = c0 + BEATS + 1 + (st ? 0 : RL);
         dn.ld  = st ? model_ld : ld;
         model_ld = dn.ld;
         done_sb.push_back(dn);
      end
   endtask

   // Monitor: compare bus beats and completions against the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_re || mem_we) begin
            if (beat_sb.size() == 0) check("unexpected_beat", 1, 0);
            else begin
               beat_t e;
               e = beat_sb.pop_front();
               check("beat_cycle", 128'(cyc), 128'(e.cyc));
               check("beat_ba", mem_ba, e.ba);
               check("beat_vo", mem_vo, e.vo);
               check("beat_wd", mem_wd, e.wd);
               check("beat_re_we", {mem_re, mem_we}, {e.re, e.we});
            end
         end else begin
            check("idle_bus", {mem_ba, mem_vo, mem_wd}, 0);
         end
         if (done) begin
            if (done_sb.size() == 0) check("unexpected_done", 1, 0);
            else begin
               done_t dn;
               dn = done_sb.pop_front();
               check("done_cycle", 128'(cyc), 128'(dn.cyc));
               check("done_ld_data", ld_data, dn.ld);
            end
         end
      end
   end

   task automatic drain_check(input string tag);
      check({tag, "_beats_left"}, 128'(beat_sb.size()), 0);
      check({tag, "_dones_left"}, 128'(done_sb.size()), 0);
   endtask

   initial begin
      int c0;

      // 1: reset held for two edges with START high
      rst_n = 1'b0;
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_re_we", {mem_re, mem_we}, 0);
      check("rst_ld_data", ld_data, 0);
      start = 1'b0;
      rst_n = 1'b1;
      mon_en = 1'b1;

      // 2: load, base 0x100, stride 1
      @(posedge clk); #1;
      c0 = cyc;
      start = 1'b1; is_store = 1'b0; base = 32'h100; stride = 8'd1;
      push_op(1'b0, 32'h100, 8'd1, '0, c0, BEATS, 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      check("t2_busy_c1", busy, 1);
      base = 32'hABCD0000; stride = 8'd9; is_store = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("t2_ld_data", ld_data, LD_T2);
      drain_check("t2");

      // 3: store, base 0, stride 2
      @(posedge clk); #1;
      c0 = cyc;
      start = 1'b1; is_store = 1'b1; base = 32'h0; stride = 8'd2;
      st_data = 128'h100F0E0D0C0B0A090807060504030201;
      push_op(1'b1, 32'h0, 8'd2, st_data, c0, BEATS, 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      st_data = '1;
      repeat (8) @(posedge clk);
      #1;
      check("t3_ld_unchanged", ld_data, LD_T2);
      drain_check("t3");

      // 4a: load with stride 0x60, lane offsets wrap mod 256
      @(posedge clk); #1;
      c0 = cyc;
      start = 1'b1; is_store = 1'b0; base = 32'h2000; stride = 8'h60;
      push_op(1'b0, 32'h2000, 8'h60, '0, c0, BEATS, 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);

      // 4b: store at 0xFFFFFFF0 with stride 4, the address wraps to 0 on beat 1
      #1;
      c0 = cyc;
      start = 1'b1; is_store = 1'b1; base = 32'hFFFFFFF0; stride = 8'd4;
      st_data = 128'hCAFEF00D_12345678_9ABCDEF0_0BADBEEF;
      push_op(1'b1, 32'hFFFFFFF0, 8'd4, st_data, c0, BEATS, 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      drain_check("t4");

      // 5: START held through a store and into its DONE cycle, so a load follows back-to-back
      c0 = cyc;
      start = 1'b1; is_store = 1'b1; base = 32'h40; stride = 8'd8;
      st_data = 128'h11112222_33334444_55556666_77778888;
      push_op(1'b1, 32'h40, 8'd8, st_data, c0, BEATS, 1'b1);
      repeat (2) @(posedge clk); #1;
      is_store = 1'b0; base = 32'h300; stride = 8'd3;
      push_op(1'b0, 32'h300, 8'd3, '0, c0 + BEATS + 1, BEATS, 1'b1);
      repeat (4) @(posedge clk); #1;
      start = 1'b0;
      check("t5_busy_second_op", busy, 1);
      repeat (10) @(posedge clk);
      #1;
      drain_check("t5");

      // 6: reset lands in cycle 3 of a load; no DONE follows and LD_DATA clears
      c0 = cyc;
      start = 1'b1; is_store = 1'b0; base = 32'h400; stride = 8'd5;
      push_op(1'b0, 32'h400, 8'd5, '0, c0, 3, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_ld = '0;
      check("t6_busy", busy, 0);
      check("t6_re", mem_re, 0);
      check("t6_ld_data", ld_data, 0);
      repeat (6) @(posedge clk);
      #1;
      check("t6_ld_data_later", ld_data, 0);
      check("t6_done", done, 0);
      drain_check("t6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
